// File: rtl/qkv_line_arbiter.sv
// Round-robin merge of the Q/K/V spike-line streams into one valid/ready stream.
// Optional overflow detection is enabled by defining QKV_ARB_OVF_DET_EN.
module qkv_line_arbiter #(
    parameter int LINE_W          = 128,
    parameter int FIFO_DEPTH      = 4,
    parameter int LINES_PER_FRAME = 32
) (
    input  logic              s_clk,
    input  logic              s_rst_n,
    input  logic [LINE_W-1:0] i_line [3],
    input  logic [2:0]        i_valid,
    output logic [LINE_W-1:0] o_line,
    output logic [1:0]        o_ch,
    output logic              o_last,
    output logic              o_valid,
    input  logic              i_ready,
    output logic              o_frame_done,
    output logic [2:0]        o_err
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = (LINES_PER_FRAME > 1) ? $clog2(LINES_PER_FRAME) : 1;

    logic [LINE_W-1:0] r_mem [3][FIFO_DEPTH];
    logic [AW:0]       r_wp [3];
    logic [AW:0]       r_rp [3];
    logic [CW-1:0]     r_cnt [3];
    logic [1:0]        r_ptr;
    logic [2:0]        r_mask;
    logic [LINE_W-1:0] r_line;
    logic [1:0]        r_ch;
    logic              r_last;
    logic              r_valid;
    logic              r_frame_done;

    logic [2:0]        w_empty;
    logic [2:0]        w_full;
    logic [2:0]        w_elig;
    logic [2:0]        w_pop;
    logic [2:0]        w_push_ok;
    logic [2:0]        w_mask_eff;
    logic [2:0]        w_mask_next;
    logic [2:0]        w_idx;
    logic              w_load;
    logic              w_close;
    logic              w_gnt_vld;
    logic [1:0]        w_gnt_ch;
    logic [1:0]        w_ptr_next;
    logic              w_gnt_last;
    logic [LINE_W-1:0] w_head;

    assign w_load  = !r_valid || i_ready;
    // Frame closes when the line that completed the mask leaves the output register.
    assign w_close = r_valid && i_ready && r_last && (r_mask == 3'b111);
    assign w_mask_eff = w_close ? 3'b000 : r_mask;

    // Per-channel FIFO status, eligibility and push/pop qualification.
    always_comb begin
        w_empty   = 3'b000;
        w_full    = 3'b000;
        w_elig    = 3'b000;
        w_pop     = 3'b000;
        w_push_ok = 3'b000;
        for (int c = 0; c < 3; c++) begin
            w_empty[c]   = (r_wp[c] == r_rp[c]);
            w_full[c]    = (r_wp[c][AW] != r_rp[c][AW]) && (r_wp[c][AW-1:0] == r_rp[c][AW-1:0]);
            w_elig[c]    = !w_empty[c] && !w_mask_eff[c];
            w_pop[c]     = w_load && w_gnt_vld && (w_gnt_ch == 2'(c));
            w_push_ok[c] = i_valid[c] && (!w_full[c] || w_pop[c]);
        end
    end

    // Round-robin pick: scan backwards so the channel nearest the pointer wins.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_ch  = 2'd0;
        w_idx     = 3'd0;
        for (int k = 2; k >= 0; k--) begin
            w_idx = {1'b0, r_ptr} + 3'(k);
            if (w_idx >= 3'd3) begin
                w_idx = w_idx - 3'd3;
            end else begin
                w_idx = w_idx;
            end
            if (w_elig[w_idx[1:0]]) begin
                w_gnt_vld = 1'b1;
                w_gnt_ch  = w_idx[1:0];
            end else begin
                w_gnt_vld = w_gnt_vld;
            end
        end
    end

    assign w_ptr_next  = (w_gnt_ch == 2'd2) ? 2'd0 : w_gnt_ch + 2'd1;
    assign w_gnt_last  = (r_cnt[w_gnt_ch] == CW'(LINES_PER_FRAME - 1));
    assign w_head      = r_mem[w_gnt_ch][r_rp[w_gnt_ch][AW-1:0]];
    assign w_mask_next = w_mask_eff |
                         ((w_load && w_gnt_vld && w_gnt_last) ? (3'b001 << w_gnt_ch) : 3'b000);

    // FIFO storage; contents need no reset because the pointers define occupancy.
    always_ff @(posedge s_clk) begin
        for (int c = 0; c < 3; c++) begin
            if (w_push_ok[c]) begin
                r_mem[c][r_wp[c][AW-1:0]] <= i_line[c];
            end
        end
    end

    // Pointers, frame counters, arbitration state and output register.
    always_ff @(posedge s_clk) begin
        if (!s_rst_n) begin
            for (int c = 0; c < 3; c++) begin
                r_wp[c]  <= '0;
                r_rp[c]  <= '0;
                r_cnt[c] <= '0;
            end
            r_ptr        <= 2'd0;
            r_mask       <= 3'b000;
            r_line       <= '0;
            r_ch         <= 2'd0;
            r_last       <= 1'b0;
            r_valid      <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            for (int c = 0; c < 3; c++) begin
                if (w_push_ok[c]) begin
                    r_wp[c] <= r_wp[c] + (AW+1)'(1);
                end
                if (w_pop[c]) begin
                    r_rp[c] <= r_rp[c] + (AW+1)'(1);
                end
            end
            if (w_load) begin
                if (w_gnt_vld) begin
                    r_line          <= w_head;
                    r_ch            <= w_gnt_ch;
                    r_last          <= w_gnt_last;
                    r_valid         <= 1'b1;
                    r_ptr           <= w_ptr_next;
                    r_cnt[w_gnt_ch] <= w_gnt_last ? '0 : r_cnt[w_gnt_ch] + CW'(1);
                end else begin
                    r_valid <= 1'b0;
                end
            end
            r_mask       <= w_mask_next;
            r_frame_done <= w_close;
        end
    end

`ifdef QKV_ARB_OVF_DET_EN
    logic [2:0] w_drop;
    logic [2:0] r_err;

    assign w_drop = i_valid & ~w_push_ok;

    // Sticky per-channel overflow flags.
    always_ff @(posedge s_clk) begin
        if (!s_rst_n) begin
            r_err <= 3'b000;
        end else begin
            r_err <= r_err | w_drop;
            for (int c = 0; c < 3; c++) begin
                if (w_drop[c]) begin
                    $error("qkv_line_arbiter: push dropped on channel %0d", c);
                end
            end
        end
    end

    assign o_err = r_err;
`else
    assign o_err = 3'b000;
`endif

    assign o_line       = r_line;
    assign o_ch         = r_ch;
    assign o_last       = r_last;
    assign o_valid      = r_valid;
    assign o_frame_done = r_frame_done;

endmodule

// File: tb/tb_qkv_line_arbiter.sv
// Self-checking bench for qkv_line_arbiter: queue-based reference model checked
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_qkv_line_arbiter;

    localparam int LW    = 128;
    localparam int DEPTH = 4;
    localparam int LPF   = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [LW-1:0] i_line [3];
    logic [2:0]    i_valid;
    logic          i_ready;
    logic [LW-1:0] o_line;
    logic [1:0]    o_ch;
    logic          o_last;
    logic          o_valid;
    logic          o_frame_done;
    logic [2:0]    o_err;

    qkv_line_arbiter #(.LINE_W(LW), .FIFO_DEPTH(DEPTH), .LINES_PER_FRAME(LPF)) dut (
        .s_clk(clk), .s_rst_n(rst_n), .i_line(i_line), .i_valid(i_valid),
        .o_line(o_line), .o_ch(o_ch), .o_last(o_last), .o_valid(o_valid),
        .i_ready(i_ready), .o_frame_done(o_frame_done), .o_err(o_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [LW-1:0] pat(input logic [7:0] b);
        return {16{b}};
    endfunction

    // Reference model state
    logic [LW-1:0] mq [3][$];
    int            m_cnt [3];
    int            m_p;
    logic [2:0]    m_mask;
    logic          m_valid, m_last, m_fd;
    logic [1:0]    m_ch;
    logic [LW-1:0] m_line;
    logic [2:0]    m_err;

    // Accept log
    int            acc_n = 0;
    logic [1:0]    acc_ch [$];
    logic          acc_last [$];
    logic [LW-1:0] acc_line [$];
    int            fd_count = 0;
    int            fd_at = 0;
    logic          prev_valid = 1'b0;
    logic [1:0]    prev_ch;
    logic          prev_last;
    logic [LW-1:0] prev_line;

    task automatic model_step();
        int g;
        logic close;
        logic [2:0] meff;
        if (!rst_n) begin
            for (int c = 0; c < 3; c++) begin mq[c].delete(); m_cnt[c] = 0; end
            m_p = 0; m_mask = 3'b000; m_valid = 1'b0; m_last = 1'b0; m_fd = 1'b0;
            m_ch = 2'd0; m_line = '0; m_err = 3'b000;
            return;
        end
        close = m_valid && i_ready && m_last && (m_mask == 3'b111);
        meff  = close ? 3'b000 : m_mask;
        g = -1;
        if (!m_valid || i_ready) begin
            for (int k = 0; k < 3; k++) begin
                int c;
                c = (m_p + k) % 3;
                if (g < 0 && mq[c].size() > 0 && !meff[c]) g = c;
            end
            if (g >= 0) begin
                m_line = mq[g].pop_front();
                m_ch   = 2'(g);
                m_cnt[g]++;
                m_last = (m_cnt[g] == LPF);
                if (m_last) begin m_cnt[g] = 0; meff[g] = 1'b1; end
                m_p = (g + 1) % 3;
                m_valid = 1'b1;
            end else begin
                m_valid = 1'b0;
            end
        end
        for (int c = 0; c < 3; c++) begin
            if (i_valid[c]) begin
                if (mq[c].size() < DEPTH) mq[c].push_back(i_line[c]);
                else m_err[c] = 1'b1;
            end
        end
        m_fd   = close;
        m_mask = meff;
    endtask

    // Compare process: step model after each edge and check DUT outputs.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && prev_valid && i_ready) begin
                acc_n++;
                acc_ch.push_back(prev_ch);
                acc_last.push_back(prev_last);
                acc_line.push_back(prev_line);
            end
            model_step();
            chk("m_valid", {127'd0, o_valid}, {127'd0, m_valid});
            if (m_valid) begin
                chk("m_line", o_line, m_line);
                chk("m_ch", {126'd0, o_ch}, {126'd0, m_ch});
                chk("m_last", {127'd0, o_last}, {127'd0, m_last});
            end
            chk("m_frame_done", {127'd0, o_frame_done}, {127'd0, m_fd});
`ifdef QKV_ARB_OVF_DET_EN
            chk("m_err", {125'd0, o_err}, {125'd0, m_err});
`else
            chk("m_err", {125'd0, o_err}, 128'd0);
`endif
            if (o_frame_done) begin fd_count++; fd_at = acc_n; end
            prev_valid = o_valid; prev_ch = o_ch; prev_last = o_last; prev_line = o_line;
        end
    end

    task automatic cyc(input logic [2:0] v, input logic [LW-1:0] l0, input logic [LW-1:0] l1,
                       input logic [LW-1:0] l2, input logic rdy, input logic rst);
        @(negedge clk);
        rst_n = rst; i_valid = v; i_line[0] = l0; i_line[1] = l1; i_line[2] = l2; i_ready = rdy;
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input logic rdy, input int n);
        for (int i = 0; i < n; i++) cyc(3'b000, '0, '0, '0, rdy, 1'b1);
    endtask

    task automatic do_reset();
        cyc(3'b000, '0, '0, '0, 1'b1, 1'b0);
    endtask

    task automatic clear_log();
        acc_n = 0; acc_ch.delete(); acc_last.delete(); acc_line.delete();
        fd_count = 0; fd_at = 0;
    endtask

    initial begin
        int seen [3];
        int lasts;
        rst_n = 1'b0; i_valid = 3'b000; i_ready = 1'b0;
        for (int c = 0; c < 3; c++) i_line[c] = '0;
        do_reset();
        do_reset();
        chk("rst_line", o_line, '0);
        chk("rst_ch", {126'd0, o_ch}, 128'd0);
        chk("rst_last", {127'd0, o_last}, 128'd0);
        chk("rst_valid", {127'd0, o_valid}, 128'd0);
        chk("rst_fd", {127'd0, o_frame_done}, 128'd0);
        chk("rst_err", {125'd0, o_err}, 128'd0);

        // T1: single push on ch1
        cyc(3'b010, '0, pat(8'hA5), '0, 1'b1, 1'b1);
        chk("t1_not_yet", {127'd0, o_valid}, 128'd0);
        idle(1'b1, 1);
        chk("t1_valid", {127'd0, o_valid}, 128'd1);
        chk("t1_ch", {126'd0, o_ch}, 128'd1);
        chk("t1_line", o_line, pat(8'hA5));
        chk("t1_last", {127'd0, o_last}, 128'd0);

        // T2: simultaneous push on all channels from p=0
        do_reset();
        cyc(3'b111, pat(8'h10), pat(8'h11), pat(8'h12), 1'b1, 1'b1);
        idle(1'b1, 1); chk("t2_first", {126'd0, o_ch}, 128'd0);
        idle(1'b1, 1); chk("t2_second", {126'd0, o_ch}, 128'd1);
        chk("t2_second_line", o_line, pat(8'h11));
        idle(1'b1, 1); chk("t2_third", {126'd0, o_ch}, 128'd2);
        idle(1'b1, 1); chk("t2_drained", {127'd0, o_valid}, 128'd0);
        cyc(3'b110, '0, pat(8'h21), pat(8'h22), 1'b1, 1'b1);
        idle(1'b1, 1); chk("t2_ptr0", {126'd0, o_ch}, 128'd1);

        // T3: back-pressure hold
        do_reset();
        cyc(3'b001, pat(8'h3C), '0, '0, 1'b0, 1'b1);
        cyc(3'b001, pat(8'h3D), '0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            chk("t3_hold_valid", {127'd0, o_valid}, 128'd1);
            chk("t3_hold_line", o_line, pat(8'h3C));
            idle(1'b0, 1);
        end
        idle(1'b1, 1);
        chk("t3_next_line", o_line, pat(8'h3D));

        // T4: full frame of 4 lines per channel
        do_reset();
        clear_log();
        for (int r = 0; r < 4; r++)
            cyc(3'b111, pat(8'(8'h40 + r)), pat(8'(8'h50 + r)), pat(8'(8'h60 + r)), 1'b1, 1'b1);
        idle(1'b1, 14);
        chk("t4_accepts", 128'(acc_n), 128'd12);
        chk("t4_fd_count", 128'(fd_count), 128'd1);
        chk("t4_fd_after12", 128'(fd_at), 128'd12);
        seen = '{0, 0, 0};
        lasts = 0;
        for (int i = 0; i < acc_n; i++) begin
            seen[acc_ch[i]]++;
            if (acc_last[i]) lasts++;
            chk("t4_last_pos", {127'd0, acc_last[i]}, {127'd0, (seen[acc_ch[i]] == 4)});
        end
        chk("t4_lasts", 128'(lasts), 128'd3);
        cyc(3'b001, pat(8'h4F), '0, '0, 1'b1, 1'b1);
        idle(1'b1, 1);
        chk("t4_restart_valid", {127'd0, o_valid}, 128'd1);
        chk("t4_restart_last", {127'd0, o_last}, 128'd0);

        // T5: overflow on ch2 while output register is blocked
        do_reset();
        cyc(3'b001, pat(8'h70), '0, '0, 1'b0, 1'b1);
        for (int i = 1; i <= 6; i++) cyc(3'b100, '0, '0, pat(8'(8'h80 + i)), 1'b0, 1'b1);
`ifdef QKV_ARB_OVF_DET_EN
        chk("t5_err", {125'd0, o_err}, 128'd4);
`else
        chk("t5_err", {125'd0, o_err}, 128'd0);
`endif
        clear_log();
        idle(1'b1, 10);
        chk("t5_accepts", 128'(acc_n), 128'd5);
        chk("t5_first_ch0", acc_line[0], pat(8'h70));
        for (int i = 1; i < acc_n; i++) begin
            chk("t5_ch2_ch", {126'd0, acc_ch[i]}, 128'd2);
            chk("t5_ch2_line", acc_line[i], pat(8'(8'h80 + i)));
        end

        // T6: reset mid-burst
        do_reset();
        cyc(3'b111, pat(8'h91), pat(8'h92), pat(8'h93), 1'b0, 1'b1);
        cyc(3'b111, pat(8'h94), pat(8'h95), pat(8'h96), 1'b0, 1'b1);
        cyc(3'b111, pat(8'h97), pat(8'h98), pat(8'h99), 1'b0, 1'b0);
        chk("t6_line", o_line, '0);
        chk("t6_valid", {127'd0, o_valid}, 128'd0);
        chk("t6_ch", {126'd0, o_ch}, 128'd0);
        chk("t6_last", {127'd0, o_last}, 128'd0);
        cyc(3'b010, '0, pat(8'hB7), '0, 1'b1, 1'b1);
        chk("t6_lat0", {127'd0, o_valid}, 128'd0);
        idle(1'b1, 1);
        chk("t6_valid1", {127'd0, o_valid}, 128'd1);
        chk("t6_line1", o_line, pat(8'hB7));
        idle(1'b1, 1);
        chk("t6_empty", {127'd0, o_valid}, 128'd0);
        idle(1'b1, 2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
